jk_excite_seq: RTL and testbench

//  Upstream command stage for a bank of WIDTH JK flip-flops. Accepts a target word over
//  a valid/ready handshake and drives the bank's j/k inputs using the JK excitation table.

---
 rtl/jk_excite_seq.sv | 123 ++++++++++++
 tb/tb_jk_excite_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_seq.sv
`default_nettype none
// ============================================================================
// Module   : jk_excite_seq
// Brief    : Drives a JK flip-flop bank toward a target word using the JK
//            excitation table, in direct (all bits) or step (one toggle) mode.
// Revision : 1.0  initial release
// ============================================================================
module jk_excite_seq #(
    parameter int WIDTH      = 4,
    parameter int MAX_DRIVES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_step,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int               CNT_W   = $clog2(MAX_DRIVES + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DRIVES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] target;
    logic             step_mode;
    logic [CNT_W-1:0] drive_cnt;
    logic             err_r;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] low_diff;
    logic             accept;
    logic             match;
    logic             exhausted;

    assign diff      = q_fb ^ target;
    // Two's-complement trick isolates the lowest set bit of the difference.
    assign low_diff  = diff & (-diff);
    assign match     = (diff == '0);
    assign exhausted = (drive_cnt == MAX_CNT);
    assign accept    = (state == S_IDLE) && cmd_valid;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_DRIVE) || (state == S_SETTLE);
    assign done      = (state == S_DONE);
    assign err       = err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            target    <= '0;
            step_mode <= 1'b0;
            drive_cnt <= '0;
            err_r     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                target    <= cmd_target;
                step_mode <= cmd_step;
                drive_cnt <= '0;
                err_r     <= 1'b0;
            end
            if ((state == S_DRIVE) && !exhausted) begin
                drive_cnt <= drive_cnt + CNT_W'(1);
            end
            if ((state == S_SETTLE) && !match && exhausted) begin
                err_r <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        j         = '0;
        k         = '0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (step_mode) begin
                    j = low_diff;
                    k = low_diff;
                end else begin
                    // Set where target is 1 and q is 0; reset where target is 0 and q is 1.
                    j = diff & target;
                    k = diff & ~target;
                end
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (match || exhausted) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_DRIVE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_excite_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_excite_seq
// Brief    : Directed bench for jk_excite_seq with a behavioural JK bank model
//            and per-bit stuck-at override on the feedback.
// Revision : 1.0  initial release
// ============================================================================
module tb_jk_excite_seq;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_target;
    logic       cmd_step;
    logic [3:0] q_fb;
    logic [3:0] j;
    logic [3:0] k;
    logic       busy;
    logic       done;
    logic       err;

    logic [3:0] bank;
    logic       load_en;
    logic [3:0] load_val;
    logic [3:0] stuck_mask;
    logic [3:0] stuck_val;

    int         checks;
    int         errors;
    int         ndrv;
    int         done_cyc;
    logic       err_seen;
    logic [3:0] jlog [0:15];
    logic [3:0] klog [0:15];

    jk_excite_seq #(.WIDTH(4), .MAX_DRIVES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .q_fb       (q_fb),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign q_fb = (bank & ~stuck_mask) | (stuck_val & stuck_mask);

    always @(posedge clk) begin
        if (load_en) begin
            bank <= load_val;
        end else begin
            for (int b = 0; b < 4; b++) begin
                case ({j[b], k[b]})
                    2'b01:   bank[b] <= 1'b0;
                    2'b10:   bank[b] <= 1'b1;
                    2'b11:   bank[b] <= ~bank[b];
                    default: bank[b] <= bank[b];
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_bank(input logic [3:0] v);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Offer one command at a negedge; returns at the negedge inside DRIVE.
    task automatic send_cmd(input logic [3:0] t, input logic s);
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_step   = s;
        check("ready_at_offer", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Called at the first DRIVE negedge; DRIVE and SETTLE alternate until done.
    task automatic run_to_done();
        logic got_done;
        got_done = 1'b0;
        ndrv     = 0;
        done_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                got_done = 1'b1;
                done_cyc = c;
                err_seen = err;
                check("done_flags", 32'({busy, cmd_ready}), 32'd0);
                break;
            end else if ((c % 2) == 0) begin
                jlog[ndrv] = j;
                klog[ndrv] = k;
                ndrv++;
                check("drive_flags", 32'({busy, cmd_ready}), 32'h2);
            end else begin
                check("settle_flags", 32'({busy, cmd_ready, |j, |k}), 32'h8);
            end
            @(negedge clk);
        end
        check("done_timeout", 32'(got_done), 32'd1);
    endtask

    int kbad;

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = 4'd0;
        cmd_step   = 1'b0;
        load_en    = 1'b0;
        load_val   = 4'd0;
        bank       = 4'd0;
        stuck_mask = 4'd0;
        stuck_val  = 4'd0;

        @(negedge clk);
        @(negedge clk);
        check("rst_outputs", 32'({j, k, busy, done, err, cmd_ready}), 32'h001);
        rst = 1'b0;
        @(negedge clk);

        // 1: async reset in the middle of a DRIVE
        load_bank(4'b0000);
        send_cmd(4'b1111, 1'b0);
        check("t1_j_before_rst", 32'(j), 32'hF);
        #1 rst = 1'b1;
        #1;
        check("t1_jk_async", 32'({j, k}), 32'h00);
        check("t1_flags_async", 32'({busy, done, err, cmd_ready}), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 2: direct mode, 0000 -> 1010
        load_bank(4'b0000);
        send_cmd(4'b1010, 1'b0);
        run_to_done();
        check("t2_ndrv", 32'(ndrv), 32'd1);
        check("t2_j", 32'(jlog[0]), 32'hA);
        check("t2_k", 32'(klog[0]), 32'h0);
        check("t2_done_cycle", 32'(done_cyc), 32'd2);
        check("t2_err", 32'(err_seen), 32'd0);
        check("t2_q", 32'(q_fb), 32'hA);
        @(negedge clk);
        check("t2_done_pulse", 32'({done, cmd_ready}), 32'h1);

        // 3: step mode, 0000 -> 0111
        load_bank(4'b0000);
        send_cmd(4'b0111, 1'b1);
        run_to_done();
        check("t3_ndrv", 32'(ndrv), 32'd3);
        check("t3_jk0", 32'({jlog[0], klog[0]}), 32'h11);
        check("t3_jk1", 32'({jlog[1], klog[1]}), 32'h22);
        check("t3_jk2", 32'({jlog[2], klog[2]}), 32'h44);
        check("t3_err", 32'(err_seen), 32'd0);
        check("t3_q", 32'(q_fb), 32'h7);

        // 4: direct mode 1111 -> 0000 with bit2 stuck at 1
        stuck_mask = 4'b0100;
        stuck_val  = 4'b0100;
        @(negedge clk);
        load_bank(4'b1111);
        send_cmd(4'b0000, 1'b0);
        run_to_done();
        check("t4_ndrv", 32'(ndrv), 32'd8);
        check("t4_jk_first", 32'({jlog[0], klog[0]}), 32'h0F);
        check("t4_jk_last", 32'({jlog[7], klog[7]}), 32'h04);
        kbad = 0;
        for (int i = 0; i < 8; i++) begin
            if (klog[i][2] !== 1'b1) kbad++;
        end
        check("t4_k2_each", 32'(kbad), 32'd0);
        check("t4_err", 32'(err_seen), 32'd1);
        @(negedge clk);
        check("t4_err_held", 32'({done, err}), 32'h1);
        stuck_mask = 4'b0000;

        // 6: target equals bank -> single all-hold drive
        load_bank(4'b0101);
        send_cmd(4'b0101, 1'b0);
        check("t6_err_cleared", 32'(err), 32'd0);
        run_to_done();
        check("t6_ndrv", 32'(ndrv), 32'd1);
        check("t6_jk", 32'({jlog[0], klog[0]}), 32'h00);
        check("t6_err", 32'(err_seen), 32'd0);

        // 5: cmd_valid held while busy must not be captured
        load_bank(4'b0000);
        send_cmd(4'b0110, 1'b0);
        cmd_valid  = 1'b1;
        cmd_target = 4'b0001;
        run_to_done();
        check("t5a_ndrv", 32'(ndrv), 32'd1);
        check("t5a_jk", 32'({jlog[0], klog[0]}), 32'h60);
        check("t5a_q", 32'(q_fb), 32'h6);
        @(negedge clk);
        check("t5_idle_ready", 32'({cmd_ready, busy, done}), 32'h4);
        @(negedge clk);
        cmd_valid = 1'b0;
        run_to_done();
        check("t5b_ndrv", 32'(ndrv), 32'd1);
        check("t5b_jk", 32'({jlog[0], klog[0]}), 32'h16);
        check("t5b_q", 32'(q_fb), 32'h1);
        check("t5b_err", 32'(err_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
